// File: rtl/code_lock_ctrl.sv
// code_lock_ctrl: safe code-entry and lock controller driven by debounced key pulses
// Ports:
//   clk        system clock
//   rst        synchronous active-low reset
//   key_pulse  one-cycle pulses: [0] inc digit, [1] enter digit, [2] clear
//   unlocked   high in OPEN or SET
//   alarm      high in LOCKOUT
//   set_mode   high in SET
//   cur_digit  digit being dialled (BCD)
//   digit_idx  position of the next digit to enter
//   fail_cnt   consecutive failed attempts
module code_lock_ctrl #(
    parameter logic [15:0] PASSWORD    = 16'h1234,
    parameter int          MAX_FAIL    = 3,
    parameter int          LOCK_CYCLES = 12_000_000,
    parameter int          OPEN_CYCLES = 60_000_000,
    parameter int          CNT_W       = 26
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] key_pulse,
    output logic       unlocked,
    output logic       alarm,
    output logic       set_mode,
    output logic [3:0] cur_digit,
    output logic [1:0] digit_idx,
    output logic [1:0] fail_cnt
);
    typedef enum logic [2:0] {ENTRY, CHECK, OPEN, SET, LOCKOUT} state_t;
    localparam logic [CNT_W-1:0] OPEN_LAST = CNT_W'(OPEN_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);
    state_t           state;
    logic [15:0]      entry_buf;
    logic [15:0]      pwd;
    logic [CNT_W-1:0] timer;
    logic             clr;
    logic             ent;
    logic             inc;
    logic [3:0]       slot;
    logic [3:0]       next_digit;
    logic [1:0]       fail_nxt;
    // clear beats enter beats inc
    assign clr        = key_pulse[2];
    assign ent        = key_pulse[1] & ~key_pulse[2];
    assign inc        = key_pulse[0] & ~|key_pulse[2:1];
    // digit 0 lives in the top nibble
    assign slot       = {2'd3 - digit_idx, 2'b00};
    assign next_digit = cur_digit == 4'd9 ? 4'd0 : cur_digit + 4'd1;
    assign fail_nxt   = fail_cnt + 2'd1;
    assign unlocked   = state == OPEN || state == SET;
    assign alarm      = state == LOCKOUT;
    assign set_mode   = state == SET;
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ENTRY;
            cur_digit <= 4'd0;
            digit_idx <= 2'd0;
            fail_cnt  <= 2'd0;
            entry_buf <= 16'd0;
            timer     <= '0;
            pwd       <= PASSWORD;
        end else begin
            case (state)
                ENTRY, SET: begin
                    if (clr) begin
                        cur_digit <= 4'd0;
                        digit_idx <= 2'd0;
                        entry_buf <= 16'd0;
                        if (state == SET) begin
                            state <= OPEN;
                            timer <= '0;
                        end
                    end else if (ent) begin
                        entry_buf[slot +: 4] <= cur_digit;
                        cur_digit            <= 4'd0;
                        digit_idx            <= digit_idx + 2'd1;
                        if (digit_idx == 2'd3) begin
                            // the last digit is still in cur_digit on this edge
                            if (state == SET) pwd <= {entry_buf[15:4], cur_digit};
                            state <= state == SET ? ENTRY : CHECK;
                        end
                    end else if (inc) begin
                        cur_digit <= next_digit;
                    end
                end
                CHECK: begin
                    timer <= '0;
                    if (entry_buf == pwd) begin
                        state    <= OPEN;
                        fail_cnt <= 2'd0;
                    end else begin
                        fail_cnt <= fail_nxt;
                        state    <= fail_nxt == 2'(MAX_FAIL) ? LOCKOUT : ENTRY;
                    end
                end
                OPEN: begin
                    if (clr || timer == OPEN_LAST) begin
                        state <= ENTRY;
                    end else if (ent) begin
                        state     <= SET;
                        cur_digit <= 4'd0;
                        digit_idx <= 2'd0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                LOCKOUT: begin
                    if (timer == LOCK_LAST) begin
                        state    <= ENTRY;
                        fail_cnt <= 2'd0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: state <= ENTRY;
            endcase
        end
    end
endmodule

// File: tb/tb_code_lock_ctrl.sv
// tb_code_lock_ctrl: directed self-checking bench for code_lock_ctrl
module tb_code_lock_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] key_pulse = 3'b000;
    logic       unlocked;
    logic       alarm;
    logic       set_mode;
    logic [3:0] cur_digit;
    logic [1:0] digit_idx;
    logic [1:0] fail_cnt;
    int errors = 0;
    int checks = 0;

    code_lock_ctrl #(
        .PASSWORD(16'h1234),
        .MAX_FAIL(3),
        .LOCK_CYCLES(16),
        .OPEN_CYCLES(32),
        .CNT_W(6)
    ) dut (
        .clk(clk),
        .rst(rst),
        .key_pulse(key_pulse),
        .unlocked(unlocked),
        .alarm(alarm),
        .set_mode(set_mode),
        .cur_digit(cur_digit),
        .digit_idx(digit_idx),
        .fail_cnt(fail_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst_n;
        logic [2:0]  keys;
        logic [10:0] exp;
    } vec_t;
    vec_t vecs[$];

    // {unlocked, alarm, set_mode, cur_digit, digit_idx, fail_cnt}
    task automatic add(input logic r, input logic [2:0] k, input logic u, input logic a,
                       input logic s, input logic [3:0] c, input logic [1:0] i, input logic [1:0] f);
        vecs.push_back('{r, k, {u, a, s, c, i, f}});
    endtask

    task automatic cyc(input logic r, input logic [2:0] k);
        rst       = r;
        key_pulse = k;
        @(posedge clk);
        #1;
        rst       = 1'b1;
        key_pulse = 3'b000;
    endtask

    task automatic chk(input string name, input logic u, input logic a, input logic s,
                       input logic [3:0] c, input logic [1:0] i, input logic [1:0] f);
        logic [10:0] got;
        logic [10:0] want;
        got  = {unlocked, alarm, set_mode, cur_digit, digit_idx, fail_cnt};
        want = {u, a, s, c, i, f};
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got u=%b a=%b s=%b cur=%0d idx=%0d fail=%0d, want u=%b a=%b s=%b cur=%0d idx=%0d fail=%0d",
                     name, got[10], got[9], got[8], got[7:4], got[3:2], got[1:0],
                     u, a, s, c, i, f);
        end
    endtask

    task automatic dial(input logic [15:0] code);
        for (int i = 0; i < 4; i++) begin
            repeat (int'(code[(3 - i) * 4 +: 4])) cyc(1'b1, 3'b001);
            cyc(1'b1, 3'b010);
        end
    endtask

    initial begin
        add(0, 3'b000, 0, 0, 0, 0, 0, 0);
        add(1, 3'b001, 0, 0, 0, 1, 0, 0);
        add(1, 3'b010, 0, 0, 0, 0, 1, 0);
        add(1, 3'b001, 0, 0, 0, 1, 1, 0);
        add(1, 3'b001, 0, 0, 0, 2, 1, 0);
        add(1, 3'b010, 0, 0, 0, 0, 2, 0);
        add(1, 3'b001, 0, 0, 0, 1, 2, 0);
        add(1, 3'b001, 0, 0, 0, 2, 2, 0);
        add(1, 3'b001, 0, 0, 0, 3, 2, 0);
        add(1, 3'b010, 0, 0, 0, 0, 3, 0);
        add(1, 3'b001, 0, 0, 0, 1, 3, 0);
        add(1, 3'b001, 0, 0, 0, 2, 3, 0);
        add(1, 3'b001, 0, 0, 0, 3, 3, 0);
        add(1, 3'b001, 0, 0, 0, 4, 3, 0);
        add(1, 3'b010, 0, 0, 0, 0, 0, 0);
        add(1, 3'b000, 1, 0, 0, 0, 0, 0);
        add(1, 3'b100, 0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 10; k++) add(1, 3'b001, 0, 0, 0, 4'(k % 10), 0, 0);
        add(1, 3'b001, 0, 0, 0, 1, 0, 0);
        add(1, 3'b011, 0, 0, 0, 0, 1, 0);
        add(1, 3'b001, 0, 0, 0, 1, 1, 0);
        add(1, 3'b001, 0, 0, 0, 2, 1, 0);
        add(1, 3'b111, 0, 0, 0, 0, 0, 0);
        add(1, 3'b001, 0, 0, 0, 1, 0, 0);
        add(1, 3'b101, 0, 0, 0, 0, 0, 0);
        add(1, 3'b001, 0, 0, 0, 1, 0, 0);
        add(0, 3'b001, 0, 0, 0, 0, 0, 0);

        @(negedge clk);
        foreach (vecs[n]) begin
            cyc(vecs[n].rst_n, vecs[n].keys);
            chk($sformatf("vec%0d", n), vecs[n].exp[10], vecs[n].exp[9], vecs[n].exp[8],
                vecs[n].exp[7:4], vecs[n].exp[3:2], vecs[n].exp[1:0]);
        end

        dial(16'h1235); cyc(1, 0); chk("fail1", 0, 0, 0, 0, 0, 1);
        dial(16'h1235); cyc(1, 0); chk("fail2", 0, 0, 0, 0, 0, 2);
        dial(16'h1235); cyc(1, 0); chk("lock_start", 0, 1, 0, 0, 0, 3);
        for (int i = 0; i < 15; i++) begin
            cyc(1, 3'(i));
            chk($sformatf("lock_hold%0d", i), 0, 1, 0, 0, 0, 3);
        end
        cyc(1, 0); chk("lock_end", 0, 0, 0, 0, 0, 0);

        dial(16'h1234); chk("check_cycle", 0, 0, 0, 0, 0, 0);
        cyc(1, 0); chk("open", 1, 0, 0, 0, 0, 0);
        for (int i = 1; i < 32; i++) begin
            cyc(1, i % 3 == 0 ? 3'b001 : 3'b000);
            chk($sformatf("open_hold%0d", i), 1, 0, 0, 0, 0, 0);
        end
        cyc(1, 0); chk("relock_timeout", 0, 0, 0, 0, 0, 0);

        dial(16'h1234); cyc(1, 0); chk("open2", 1, 0, 0, 0, 0, 0);
        cyc(1, 3'b100); chk("relock_clear", 0, 0, 0, 0, 0, 0);

        dial(16'h1234); cyc(1, 0);
        cyc(1, 3'b010); chk("set_enter", 1, 0, 1, 0, 0, 0);
        cyc(1, 3'b001); chk("set_inc", 1, 0, 1, 1, 0, 0);
        cyc(1, 3'b100); chk("set_abort", 1, 0, 0, 0, 0, 0);
        cyc(1, 3'b100); chk("abort_relock", 0, 0, 0, 0, 0, 0);

        dial(16'h1234); cyc(1, 0);
        cyc(1, 3'b010); chk("set_enter2", 1, 0, 1, 0, 0, 0);
        dial(16'h9007); chk("set_done", 0, 0, 0, 0, 0, 0);
        dial(16'h1234); cyc(1, 0); chk("old_pwd_fails", 0, 0, 0, 0, 0, 1);
        dial(16'h9007); cyc(1, 0); chk("new_pwd_opens", 1, 0, 0, 0, 0, 0);

        cyc(1, 3'b010); chk("set_enter3", 1, 0, 1, 0, 0, 0);
        cyc(1, 3'b001); cyc(1, 3'b001); chk("set_dial", 1, 0, 1, 2, 0, 0);
        cyc(0, 3'b000); chk("reset_in_set", 0, 0, 0, 0, 0, 0);
        dial(16'h9007); cyc(1, 0); chk("changed_pwd_gone", 0, 0, 0, 0, 0, 1);
        dial(16'h1234); cyc(1, 0); chk("default_pwd_back", 1, 0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
